// File: rtl/branch_predict_resolve.sv
// Execute-stage branch resolve unit with a per-PC table of saturating direction counters.
// Optional BRANCH_STATS_EN adds conditional-branch and mispredict counters.
module branch_predict_resolve #(
  parameter int DATA_W    = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CTR_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pred_pc,
  output logic              pred_taken,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_pc,
  input  logic [5:0]        res_opcode,
  input  logic [5:0]        res_funct,
  input  logic [4:0]        res_rt,
  input  logic [25:0]       res_imm26,
  input  logic [DATA_W-1:0] res_src_a,
  input  logic [DATA_W-1:0] res_src_b,
  input  logic              res_pred_taken,
  input  logic              flush,
  output logic              out_valid,
  output logic              take_branch,
  output logic              mispredict,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              is_cond
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};

  typedef enum logic [1:0] {
    KIND_NONE,
    KIND_COND,
    KIND_JUMP,
    KIND_JREG
  } kind_t;

  logic [CTR_W-1:0]  bht [BHT_DEPTH];
  logic [IDX_W-1:0]  pred_idx;
  logic [IDX_W-1:0]  res_idx;
  logic [CTR_W-1:0]  cur_ctr;
  logic [CTR_W-1:0]  new_ctr;
  logic [DATA_W-1:0] pc4;
  logic [DATA_W-1:0] br_target;
  logic [DATA_W-1:0] j_target;
  logic [15:0]       imm16;
  logic              accept;
  logic              a_neg;
  logic              a_zero;
  kind_t             kind;
  logic              actual;
  logic              nxt_take;
  logic              nxt_mis;
  logic [DATA_W-1:0] nxt_redirect;
  logic              unused_pred_bits;

  assign pred_idx   = pred_pc[IDX_W+1:2];
  assign res_idx    = res_pc[IDX_W+1:2];
  assign pred_taken = bht[pred_idx][CTR_W-1];
  assign unused_pred_bits = ^{pred_pc[DATA_W-1:IDX_W+2], pred_pc[1:0]};

  assign accept    = res_valid & ~flush;
  assign imm16     = res_imm26[15:0];
  assign pc4       = res_pc + DATA_W'(4);
  assign br_target = pc4 + {{(DATA_W-18){imm16[15]}}, imm16, 2'b00};
  assign j_target  = {pc4[DATA_W-1:28], res_imm26, 2'b00};
  assign a_neg     = res_src_a[DATA_W-1];
  assign a_zero    = (res_src_a == '0);

  always_comb begin
    kind   = KIND_NONE;
    actual = 1'b0;
    unique case (res_opcode)
      6'h04: begin kind = KIND_COND; actual = (res_src_a == res_src_b); end
      6'h05: begin kind = KIND_COND; actual = (res_src_a != res_src_b); end
      6'h06: begin kind = KIND_COND; actual = a_neg | a_zero; end
      6'h07: begin kind = KIND_COND; actual = ~a_neg & ~a_zero; end
      6'h01: begin
        if (res_rt == 5'b00000) begin
          kind = KIND_COND; actual = a_neg;
        end else if (res_rt == 5'b00001) begin
          kind = KIND_COND; actual = ~a_neg;
        end
      end
      6'h02, 6'h03: kind = KIND_JUMP;
      6'h00: if (res_funct == 6'h08 || res_funct == 6'h09) kind = KIND_JREG;
      default: kind = KIND_NONE;
    endcase
  end

  // J/JAL were already redirected upstream, so only JR/JALR force a mispredict
  always_comb begin
    nxt_take     = 1'b0;
    nxt_mis      = 1'b0;
    nxt_redirect = pc4;
    unique case (kind)
      KIND_COND: begin
        nxt_take     = actual;
        nxt_mis      = actual ^ res_pred_taken;
        nxt_redirect = actual ? br_target : pc4;
      end
      KIND_JUMP: begin
        nxt_take     = 1'b1;
        nxt_redirect = j_target;
      end
      KIND_JREG: begin
        nxt_take     = 1'b1;
        nxt_mis      = 1'b1;
        nxt_redirect = res_src_a;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      take_branch <= 1'b0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      is_cond     <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      take_branch <= nxt_take;
      mispredict  <= nxt_mis;
      redirect_pc <= nxt_redirect;
      is_cond     <= (kind == KIND_COND);
    end else begin
      out_valid   <= 1'b0;
      take_branch <= 1'b0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      is_cond     <= 1'b0;
    end
  end

  assign cur_ctr = bht[res_idx];

  always_comb begin
    new_ctr = cur_ctr;
    if (actual) begin
      if (cur_ctr != CTR_MAX) new_ctr = cur_ctr + CTR_W'(1);
    end else begin
      if (cur_ctr != '0) new_ctr = cur_ctr - CTR_W'(1);
    end
  end

  // Flop array so every counter can be restored asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < unsigned'(BHT_DEPTH); i++) bht[i] <= CTR_INIT;
    end else if (accept && kind == KIND_COND) begin
      bht[res_idx] <= new_ctr;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (accept && kind == KIND_COND) begin
      if (stat_branches != '1) stat_branches <= stat_branches + 32'd1;
      if (nxt_mis && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`else
  // statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench for branch_predict_resolve: decode, targets, mispredicts, counter training, reset.
module tb_branch_predict_resolve;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [5:0]  res_opcode;
  logic [5:0]  res_funct;
  logic [4:0]  res_rt;
  logic [25:0] res_imm26;
  logic [31:0] res_src_a;
  logic [31:0] res_src_b;
  logic        res_pred_taken;
  logic        flush;
  logic        out_valid;
  logic        take_branch;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        is_cond;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
  int unsigned exp_br = 0;
  int unsigned exp_mis = 0;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  branch_predict_resolve #(.DATA_W(32), .BHT_DEPTH(64), .CTR_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .res_valid      (res_valid),
    .res_pc         (res_pc),
    .res_opcode     (res_opcode),
    .res_funct      (res_funct),
    .res_rt         (res_rt),
    .res_imm26      (res_imm26),
    .res_src_a      (res_src_a),
    .res_src_b      (res_src_b),
    .res_pred_taken (res_pred_taken),
    .flush          (flush),
    .out_valid      (out_valid),
    .take_branch    (take_branch),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .is_cond        (is_cond)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic setup(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                       input logic [31:0] pc, input logic [25:0] imm,
                       input logic [31:0] a, input logic [31:0] b, input logic pt);
    res_valid      = 1'b1;
    res_opcode     = op;
    res_funct      = fn;
    res_rt         = rt;
    res_pc         = pc;
    res_imm26      = imm;
    res_src_a      = a;
    res_src_b      = b;
    res_pred_taken = pt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                       input logic [31:0] pc, input logic [25:0] imm,
                       input logic [31:0] a, input logic [31:0] b, input logic pt);
    setup(op, fn, rt, pc, imm, a, b, pt);
    step();
  endtask

  task automatic expect_out(input string tag, input logic v, input logic t, input logic m,
                            input logic [31:0] r, input logic c);
    check({tag, ".valid"},    out_valid,   v);
    check({tag, ".take"},     take_branch, t);
    check({tag, ".mis"},      mispredict,  m);
    check({tag, ".redirect"}, redirect_pc, r);
    check({tag, ".cond"},     is_cond,     c);
`ifdef BRANCH_STATS_EN
    if (v && c) exp_br++;
    if (v && c && m) exp_mis++;
`endif
  endtask

  task automatic peek(input string tag, input logic [31:0] pc, input logic exp);
    pred_pc = pc;
    #1;
    check(tag, pred_taken, exp);
  endtask

  task automatic bubble();
    res_valid = 1'b0;
    step();
    expect_out("bubble", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; pred_pc = '0;
    setup(6'h00, 6'h00, 5'h00, 32'h0, 26'h0, 32'h0, 32'h0, 1'b0);
    res_valid = 1'b0;
    step();
    expect_out("reset", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 64; i++) peek($sformatf("reset.pred%0d", i), 32'(i) << 2, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // counter at index 0: 01 -> 10 -> 11 -> 11 -> 11
    drive(OP_BEQ, 6'h0, 5'h0, 32'h100, 26'h0003, 32'd5, 32'd5, 1'b0);
    expect_out("beq1", 1'b1, 1'b1, 1'b1, 32'h110, 1'b1);
    peek("beq1.pred", 32'h100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(OP_BEQ, 6'h0, 5'h0, 32'h100, 26'h0003, 32'd5, 32'd5, 1'b1);
      expect_out("beq_more", 1'b1, 1'b1, 1'b0, 32'h110, 1'b1);
    end
    peek("beq_sat.pred", 32'h100, 1'b1);
    drive(OP_BEQ, 6'h0, 5'h0, 32'h100, 26'h0003, 32'd5, 32'd6, 1'b1);
    expect_out("beq_nt1", 1'b1, 1'b0, 1'b1, 32'h104, 1'b1);
    peek("beq_nt1.pred", 32'h100, 1'b1);
    drive(OP_BEQ, 6'h0, 5'h0, 32'h100, 26'h0003, 32'd5, 32'd6, 1'b1);
    expect_out("beq_nt2", 1'b1, 1'b0, 1'b1, 32'h104, 1'b1);
    peek("beq_nt2.pred", 32'h100, 1'b0);

    drive(OP_BNE, 6'h0, 5'h0, 32'h200, 26'h0FFFF, 32'd1, 32'd2, 1'b1);
    expect_out("bne", 1'b1, 1'b1, 1'b0, 32'h200, 1'b1);
    peek("bne.pred", 32'h200, 1'b1);
    bubble();

    drive(OP_BLEZ, 6'h0, 5'h0, 32'h304, 26'h0010, 32'h8000_0000, 32'h0, 1'b0);
    expect_out("blez", 1'b1, 1'b1, 1'b1, 32'h348, 1'b1);

    // index 2: 01 -> 00 -> 00 (floor) -> 01 -> 10
    drive(OP_BGTZ, 6'h0, 5'h0, 32'h308, 26'h0002, 32'h0, 32'h0, 1'b0);
    expect_out("bgtz0", 1'b1, 1'b0, 1'b0, 32'h30C, 1'b1);
    drive(OP_BGTZ, 6'h0, 5'h0, 32'h308, 26'h0002, 32'h0, 32'h0, 1'b0);
    peek("bgtz_floor.pred", 32'h308, 1'b0);
    drive(OP_BGTZ, 6'h0, 5'h0, 32'h308, 26'h0002, 32'h1, 32'h0, 1'b0);
    expect_out("bgtz1", 1'b1, 1'b1, 1'b1, 32'h314, 1'b1);
    peek("bgtz_up1.pred", 32'h308, 1'b0);
    drive(OP_BGTZ, 6'h0, 5'h0, 32'h308, 26'h0002, 32'h1, 32'h0, 1'b0);
    peek("bgtz_up2.pred", 32'h308, 1'b1);

    drive(OP_REGIMM, 6'h0, 5'b00001, 32'h310, 26'h0001, 32'h0, 32'h0, 1'b1);
    expect_out("bgez", 1'b1, 1'b1, 1'b0, 32'h318, 1'b1);
    drive(OP_REGIMM, 6'h0, 5'b00000, 32'h314, 26'h0001, 32'hFFFF_FFFF, 32'h0, 1'b0);
    expect_out("bltz", 1'b1, 1'b1, 1'b1, 32'h31C, 1'b1);
    drive(OP_REGIMM, 6'h0, 5'b10000, 32'h318, 26'h0001, 32'h0, 32'h0, 1'b0);
    expect_out("regimm_nb", 1'b1, 1'b0, 1'b0, 32'h31C, 1'b0);
    peek("regimm_nb.pred", 32'h318, 1'b0);
    drive(OP_BEQ, 6'h0, 5'h0, 32'h318, 26'h0001, 32'd7, 32'd7, 1'b0);
    expect_out("beq318", 1'b1, 1'b1, 1'b1, 32'h320, 1'b1);
    peek("regimm_nb.untouched", 32'h318, 1'b1);

    drive(OP_SPECIAL, 6'h08, 5'h0, 32'h31C, 26'h0, 32'h0040_0020, 32'h0, 1'b0);
    expect_out("jr", 1'b1, 1'b1, 1'b1, 32'h0040_0020, 1'b0);
    peek("jr.pred", 32'h31C, 1'b0);

    drive(OP_J, 6'h0, 5'h0, 32'hF000_0000, 26'h0000010, 32'h0, 32'h0, 1'b0);
    expect_out("j", 1'b1, 1'b1, 1'b0, 32'hF000_0040, 1'b0);
    drive(OP_BEQ, 6'h0, 5'h0, 32'h100, 26'h0003, 32'd1, 32'd2, 1'b1);
    expect_out("beq_after_j", 1'b1, 1'b0, 1'b1, 32'h104, 1'b1);
    peek("j.untrained", 32'h100, 1'b0);

    // same-index lookup during resolve sees the pre-update counter
    pred_pc = 32'h308;
    setup(OP_BGTZ, 6'h0, 5'h0, 32'h308, 26'h0002, 32'h0, 32'h0, 1'b1);
    #1;
    check("same.old", pred_taken, 1'b1);
    step();
    check("same.new", pred_taken, 1'b0);
    expect_out("same", 1'b1, 1'b0, 1'b1, 32'h30C, 1'b1);

    flush = 1'b1;
    drive(OP_BEQ, 6'h0, 5'h0, 32'h31C, 26'h0001, 32'd3, 32'd3, 1'b0);
    flush = 1'b0;
    expect_out("flush", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    peek("flush.pred", 32'h31C, 1'b0);

`ifdef BRANCH_STATS_EN
    check("stat_branches", stat_branches, exp_br);
    check("stat_mispredicts", stat_mispredicts, exp_mis);
`endif

    drive(OP_BLEZ, 6'h0, 5'h0, 32'h304, 26'h0010, 32'h0, 32'h0, 1'b1);
    expect_out("blez0", 1'b1, 1'b1, 1'b0, 32'h348, 1'b1);
    peek("pre_rst.pred", 32'h304, 1'b1);
    setup(OP_BEQ, 6'h0, 5'h0, 32'h304, 26'h0001, 32'd9, 32'd9, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    expect_out("rst_async", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    peek("rst_async.pred", 32'h304, 1'b0);
    step();
    @(negedge clk);
    rst = 1'b0;
    res_valid = 1'b0;
    peek("rst_discard.pred", 32'h304, 1'b0);
`ifdef BRANCH_STATS_EN
    exp_br = 0;
    exp_mis = 0;
    check("stat_branches.rst", stat_branches, 32'h0);
    check("stat_mispredicts.rst", stat_mispredicts, 32'h0);
`endif
    drive(OP_BEQ, 6'h0, 5'h0, 32'h304, 26'h0001, 32'd9, 32'd9, 1'b0);
    expect_out("post_rst", 1'b1, 1'b1, 1'b1, 32'h30C, 1'b1);
    peek("post_rst.pred", 32'h304, 1'b1);
    bubble();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
Execute-stage branch unit with a direction predictor. It resolves MIPS branches and jumps, computes the redirect PC and flags mispredicts against a per-PC table of 2-bit saturating counters. The table is read by fetch and trained at resolve. It sits between ID/EX and the fetch PC mux and replaces the purely combinational take-branch decode.

Parameters:
DATA_W, 32, operand and PC width.
BHT_DEPTH, 64, number of predictor entries; power of 2, minimum 4.
CTR_W, 2, counter width; counter MSB=1 means predict taken.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
pred_pc  in  DATA_W  fetch PC to look up
pred_taken  out  1  combinational MSB of BHT[index(pred_pc)]
res_valid  in  1  instruction in execute is valid
res_pc  in  DATA_W  PC of resolving instruction
res_opcode  in  6  opcode
res_funct  in  6  funct (opcode 0)
res_rt  in  5  rt field (REGIMM)
res_imm26  in  26  instr[25:0]; low 16 bits are branch offset
res_src_a  in  DATA_W  rs value (forwarded)
res_src_b  in  DATA_W  rt value (forwarded)
res_pred_taken  in  1  prediction carried down pipe for this instruction
flush  in  1  kill instruction in execute this cycle
out_valid  out  1  registered result valid
take_branch  out  1  registered actual outcome
mispredict  out  1  registered redirect request
redirect_pc  out  DATA_W  registered redirect target
is_cond  out  1  registered: instruction was conditional branch

Behaviour:
- index(pc) = pc[log2(BHT_DEPTH)+1:2].
- Accept when res_valid & ~flush; the flush case is treated as a bubble with no table update.
- Decode (accepted):
  - BEQ (04): taken if a==b.
  - BNE (05): taken if a!=b.
  - BLEZ (06): taken if signed a<=0.
  - BGTZ (07): taken if signed a>0.
  - REGIMM (01): rt=00000 BLTZ (signed a<0); rt=00001 BGEZ (signed a>=0); any other rt is not a branch.
  - J (02), JAL (03): unconditional.
  - opcode 00 with funct 08 (JR) or 09 (JALR): unconditional register jump.
  - All else: not a branch; out_valid still pulses, all flags 0.
- Targets:
  - branch: pc+4+(sext(imm16)<<2), wrapping mod 2^DATA_W.
  - J/JAL: {(pc+4)[DATA_W-1:28], imm26, 2'b00}.
  - JR/JALR: src_a unmodified.
  - fallthrough: pc+4.
  - No delay slot.
- Mispredict rules:
  - conditional: mispredict = actual ^ res_pred_taken; redirect_pc = actual ? target : pc+4.
  - J/JAL: take_branch=1, mispredict=0, since fetch/decode already redirected.
  - JR/JALR: take_branch=1, mispredict=1, redirect_pc=src_a.
  - non-branch: mispredict=0, redirect_pc=pc+4.
- Latency: all outputs registered; valid 1 cycle after accept. out_valid=0 cycle after a bubble; other outputs then hold 0.
- Training (conditional branches only):
  - Same edge as output register: counter at index(res_pc) increments if taken, decrements otherwise.
  - Saturates at 0 and 2^CTR_W-1.
  - Unconditional jumps never train.
- Same-cycle read/write of one index: pred_taken shows the pre-update value. The new value is visible the following cycle.
- Reset (async, any time, including mid-update):
  - all outputs 0;
  - every counter set to weakly not-taken (2^(CTR_W-1)-1, i.e. 01 for CTR_W=2);
  - an update in flight at reset is discarded.
- Table is flop-based so it resets asynchronously; no RAM inference.

Optional Feature:
BRANCH_STATS_EN:
- Defined: adds outputs stat_branches and stat_mispredicts, both 32 bits, reset to 0.
  - Count accepted conditional branches and conditional mispredicts respectively.
  - JR/JALR are excluded.
  - Saturate at 0xFFFFFFFF.
  - Update on the same edge as out_valid.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then read every index -> pred_taken=0. Assert rst mid-run -> outputs 0 at once, table back to 01.
- BEQ at pc 0x100, a=b=5, imm16=0x0003, pred=0 -> next cycle take_branch=1, mispredict=1, redirect_pc=0x110. Two more taken resolves -> pred_taken(0x100)=1. A fourth taken resolve holds counter at 11.
- BNE pc 0x200, imm16=0xFFFF, a=1, b=2, pred=1 -> take=1, mispredict=0, redirect_pc=0x200. BLEZ a=0x80000000 -> taken. BGTZ a=0 -> not taken.
- REGIMM rt=00001 with a=0 -> taken. rt=00000 with a=0xFFFFFFFF -> taken. rt=10000 -> non-branch, no BHT change.
- JR a=0x00400020 -> mispredict=1, redirect_pc=0x00400020. J at pc 0xF000_0000, imm26=0x0000010 -> take=1, mispredict=0, redirect_pc=0xF0000040. Neither trains the table.
- Resolve and lookup the same index in one cycle -> old pred_taken that cycle, new value next cycle. flush with res_valid -> out_valid=0, counter unchanged. With BRANCH_STATS_EN defined -> stat counts match the scoreboard.
